// File: rtl/id_operand_collect_pkg.sv
// Shared definitions for the ID-stage operand collector: default widths,
// the control-state encoding and the saturating counter helper.
package id_operand_collect_pkg;

   // Default widths shared with the bypass network.
   localparam int AW_DEF   = 5;    // register address width, r0 reads as zero
   localparam int DW_DEF   = 32;   // operand / forwarded data width
   localparam int TAGW_DEF = 32;   // opaque instruction tag (PC)
   localparam int CNTW     = 32;   // stall counter width

   // Width of one forwarding triple {we, rdy, addr, data} as the bypass
   // network packs it; WB has no rdy bit but keeps the same layout.
   localparam int FWDW_DEF = 2 + AW_DEF + DW_DEF;

   // Stage control: the stage either holds a decoded instruction or not.
   typedef enum logic {
      ST_EMPTY = 1'b0,
      ST_HELD  = 1'b1
   } ctrl_state_e;

   // Increment that sticks at all-ones instead of wrapping.
   function automatic logic [CNTW-1:0] sat_inc(input logic [CNTW-1:0] v);
      return (&v) ? v : v + {{(CNTW-1){1'b0}}, 1'b1};
   endfunction

endpackage

// File: rtl/id_operand_collect_if.sv
// Bus bundle for the operand collector: IF-side handshake, regfile read
// port, the three forwarding triples, EXE-side handshake and the stall
// counter.
//
// Handshake semantics (both sides): a transfer happens on a rising edge
// where valid and allowin are both 1. The producer keeps valid and its
// payload stable until that edge; allowin may depend combinationally on
// the consumer's downstream allowin, never on the producer's valid.
interface id_operand_collect_if #(
   parameter int AW   = 5,
   parameter int DW   = 32,
   parameter int TAGW = 32
);

   logic            flush;
   // IF side
   logic            in_valid;
   logic            in_allowin;
   logic [TAGW-1:0] in_tag;
   logic [AW-1:0]   in_src1;
   logic [AW-1:0]   in_src2;
   logic            in_use1;
   logic            in_use2;
   // regfile read port
   logic [AW-1:0]   rf_raddr1;
   logic [AW-1:0]   rf_raddr2;
   logic [DW-1:0]   rf_rdata1;
   logic [DW-1:0]   rf_rdata2;
   // forwarding from younger stages
   logic            exe_fwd_we;
   logic [AW-1:0]   exe_fwd_addr;
   logic [DW-1:0]   exe_fwd_data;
   logic            exe_fwd_rdy;
   logic            mem_fwd_we;
   logic [AW-1:0]   mem_fwd_addr;
   logic [DW-1:0]   mem_fwd_data;
   logic            mem_fwd_rdy;
   logic            wb_fwd_we;
   logic [AW-1:0]   wb_fwd_addr;
   logic [DW-1:0]   wb_fwd_data;
   // EXE side
   logic            out_valid;
   logic            out_allowin;
   logic [TAGW-1:0] out_tag;
   logic [DW-1:0]   out_op1;
   logic [DW-1:0]   out_op2;
   logic [31:0]     stall_cnt;

   // The collector itself.
   modport slave (
      input  flush,
      input  in_valid, in_tag, in_src1, in_src2, in_use1, in_use2,
      output in_allowin,
      output rf_raddr1, rf_raddr2,
      input  rf_rdata1, rf_rdata2,
      input  exe_fwd_we, exe_fwd_addr, exe_fwd_data, exe_fwd_rdy,
      input  mem_fwd_we, mem_fwd_addr, mem_fwd_data, mem_fwd_rdy,
      input  wb_fwd_we, wb_fwd_addr, wb_fwd_data,
      output out_valid, out_tag, out_op1, out_op2,
      input  out_allowin,
      output stall_cnt
   );

   // The surrounding pipeline (IF/ID register, regfile, bypass, EXE).
   modport master (
      output flush,
      output in_valid, in_tag, in_src1, in_src2, in_use1, in_use2,
      input  in_allowin,
      input  rf_raddr1, rf_raddr2,
      output rf_rdata1, rf_rdata2,
      output exe_fwd_we, exe_fwd_addr, exe_fwd_data, exe_fwd_rdy,
      output mem_fwd_we, mem_fwd_addr, mem_fwd_data, mem_fwd_rdy,
      output wb_fwd_we, wb_fwd_addr, wb_fwd_data,
      input  out_valid, out_tag, out_op1, out_op2,
      output out_allowin,
      input  stall_cnt
   );

endinterface

// File: rtl/id_operand_collect_fwd_select.sv
// Resolves one source operand from the bypass network or the regfile and
// flags whether the producing stage has not got the data yet.
module id_operand_collect_fwd_select #(
   parameter int AW = 5,
   parameter int DW = 32
) (
   input  logic [AW-1:0] i_src,
   input  logic          i_use,
   input  logic          i_exe_we,
   input  logic [AW-1:0] i_exe_addr,
   input  logic [DW-1:0] i_exe_data,
   input  logic          i_exe_rdy,
   input  logic          i_mem_we,
   input  logic [AW-1:0] i_mem_addr,
   input  logic [DW-1:0] i_mem_data,
   input  logic          i_mem_rdy,
   input  logic          i_wb_we,
   input  logic [AW-1:0] i_wb_addr,
   input  logic [DW-1:0] i_wb_data,
   input  logic [DW-1:0] i_rf_data,
   output logic [DW-1:0] o_value,
   output logic          o_hazard
);

   logic w_live;
   logic w_exe_hit;
   logic w_mem_hit;
   logic w_wb_hit;

   // r0 and unused sources never depend on anything.
   assign w_live    = i_use && (i_src != '0);
   assign w_exe_hit = i_exe_we && (i_exe_addr == i_src);
   assign w_mem_hit = i_mem_we && (i_mem_addr == i_src);
   assign w_wb_hit  = i_wb_we  && (i_wb_addr  == i_src);

   // Youngest matching stage wins; a hazarded match does not fall through
   // to an older stage, since the older copy is stale.
   always_comb begin
      o_value  = '0;
      o_hazard = 1'b0;
      if (w_live) begin
         if (w_exe_hit) begin
            o_value  = i_exe_data;
            o_hazard = !i_exe_rdy;
         end else if (w_mem_hit) begin
            o_value  = i_mem_data;
            o_hazard = !i_mem_rdy;
         end else if (w_wb_hit) begin
            o_value  = i_wb_data;
         end else begin
            o_value  = i_rf_data;
         end
      end
   end

endmodule

// File: rtl/id_operand_collect.sv
// ID-stage operand collector: holds one decoded instruction, resolves both
// sources through the bypass network, stalls on not-ready producers and
// presents registered operands to EXE. Counts hazard-stall cycles.
module id_operand_collect
   import id_operand_collect_pkg::*;
#(
   parameter int AW   = AW_DEF,
   parameter int DW   = DW_DEF,
   parameter int TAGW = TAGW_DEF
) (
   input  logic                 clk,
   input  logic                 reset,
   id_operand_collect_if.slave  bus,
   output ctrl_state_e          o_dbg_state
);

   // control state: EMPTY / HELD mirrors the hold-register valid bit
   ctrl_state_e     r_state;
   ctrl_state_e     w_state_nxt;

   // hold register (decoded instruction waiting for its operands)
   logic [TAGW-1:0] r_tag;
   logic [AW-1:0]   r_src1;
   logic [AW-1:0]   r_src2;
   logic            r_use1;
   logic            r_use2;

   // output stage towards EXE
   logic            r_out_valid;
   logic [TAGW-1:0] r_out_tag;
   logic [DW-1:0]   r_out_op1;
   logic [DW-1:0]   r_out_op2;
   logic [CNTW-1:0] r_stall_cnt;

   logic            w_hold_valid;
   logic [DW-1:0]   w_val1;
   logic [DW-1:0]   w_val2;
   logic            w_haz1;
   logic            w_haz2;
   logic            w_ready_go;
   logic            w_fire;
   logic            w_allowin;
   logic            w_accept;

   assign w_hold_valid = (r_state == ST_HELD);
   assign w_ready_go   = w_hold_valid && !w_haz1 && !w_haz2;
   assign w_fire       = w_ready_go && (!r_out_valid || bus.out_allowin);
   assign w_allowin    = !w_hold_valid || w_fire;
   assign w_accept     = bus.in_valid && w_allowin;

   assign bus.in_allowin = w_allowin;
   assign bus.rf_raddr1  = r_src1;
   assign bus.rf_raddr2  = r_src2;
   assign bus.out_valid  = r_out_valid;
   assign bus.out_tag    = r_out_tag;
   assign bus.out_op1    = r_out_op1;
   assign bus.out_op2    = r_out_op2;
   assign bus.stall_cnt  = r_stall_cnt;
   assign o_dbg_state    = r_state;

   id_operand_collect_fwd_select #(.AW(AW), .DW(DW)) u_sel1 (
      .i_src      (r_src1),
      .i_use      (r_use1),
      .i_exe_we   (bus.exe_fwd_we),
      .i_exe_addr (bus.exe_fwd_addr),
      .i_exe_data (bus.exe_fwd_data),
      .i_exe_rdy  (bus.exe_fwd_rdy),
      .i_mem_we   (bus.mem_fwd_we),
      .i_mem_addr (bus.mem_fwd_addr),
      .i_mem_data (bus.mem_fwd_data),
      .i_mem_rdy  (bus.mem_fwd_rdy),
      .i_wb_we    (bus.wb_fwd_we),
      .i_wb_addr  (bus.wb_fwd_addr),
      .i_wb_data  (bus.wb_fwd_data),
      .i_rf_data  (bus.rf_rdata1),
      .o_value    (w_val1),
      .o_hazard   (w_haz1)
   );

   id_operand_collect_fwd_select #(.AW(AW), .DW(DW)) u_sel2 (
      .i_src      (r_src2),
      .i_use      (r_use2),
      .i_exe_we   (bus.exe_fwd_we),
      .i_exe_addr (bus.exe_fwd_addr),
      .i_exe_data (bus.exe_fwd_data),
      .i_exe_rdy  (bus.exe_fwd_rdy),
      .i_mem_we   (bus.mem_fwd_we),
      .i_mem_addr (bus.mem_fwd_addr),
      .i_mem_data (bus.mem_fwd_data),
      .i_mem_rdy  (bus.mem_fwd_rdy),
      .i_wb_we    (bus.wb_fwd_we),
      .i_wb_addr  (bus.wb_fwd_addr),
      .i_wb_data  (bus.wb_fwd_data),
      .i_rf_data  (bus.rf_rdata2),
      .o_value    (w_val2),
      .o_hazard   (w_haz2)
   );

   // control state register
   always_ff @(posedge clk) begin
      if (reset) begin
         r_state <= ST_EMPTY;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   // next state: flush empties; accept (possibly a reload on fire) holds;
   // a fire without reload empties; hazard/back-pressure keeps holding
   always_comb begin
      w_state_nxt = r_state;
      if (bus.flush) begin
         w_state_nxt = ST_EMPTY;
      end else if (w_accept) begin
         w_state_nxt = ST_HELD;
      end else if (w_fire) begin
         w_state_nxt = ST_EMPTY;
      end
   end

   // hold register payload: captured on accept, ignored during flush
   always_ff @(posedge clk) begin
      if (reset) begin
         r_tag  <= '0;
         r_src1 <= '0;
         r_src2 <= '0;
         r_use1 <= 1'b0;
         r_use2 <= 1'b0;
      end else if (!bus.flush && w_accept) begin
         r_tag  <= bus.in_tag;
         r_src1 <= bus.in_src1;
         r_src2 <= bus.in_src2;
         r_use1 <= bus.in_use1;
         r_use2 <= bus.in_use2;
      end
   end

   // output stage: load on fire, drain once EXE takes it, hold otherwise
   always_ff @(posedge clk) begin
      if (reset) begin
         r_out_valid <= 1'b0;
         r_out_tag   <= '0;
         r_out_op1   <= '0;
         r_out_op2   <= '0;
      end else if (bus.flush) begin
         r_out_valid <= 1'b0;
      end else if (w_fire) begin
         r_out_valid <= 1'b1;
         r_out_tag   <= r_tag;
         r_out_op1   <= w_val1;
         r_out_op2   <= w_val2;
      end else if (bus.out_allowin) begin
         r_out_valid <= 1'b0;
      end
   end

   // stall counter: counts hazard cycles only, survives flush
   always_ff @(posedge clk) begin
      if (reset) begin
         r_stall_cnt <= '0;
      end else if (w_hold_valid && !w_ready_go && !bus.flush) begin
         r_stall_cnt <= sat_inc(r_stall_cnt);
      end
   end

endmodule

// File: tb/tb_id_operand_collect.sv
// Directed bench for id_operand_collect: cycle-level behavioural model of
// the stage, per-cycle compare against it, plus a transfer scoreboard fed
// with hand-computed operand triples.
module tb_id_operand_collect;
   import id_operand_collect_pkg::*;

   // ---------------- clock / reset ----------------
   logic        clk = 1'b0;
   logic        reset;
   ctrl_state_e dbg_state;

   always #5 clk = ~clk;

   id_operand_collect_if #(.AW(5), .DW(32), .TAGW(32)) bus ();

   id_operand_collect dut (
      .clk         (clk),
      .reset       (reset),
      .bus         (bus),
      .o_dbg_state (dbg_state)
   );

   logic [31:0] rf_mem [32];
   assign bus.rf_rdata1 = rf_mem[bus.rf_raddr1];
   assign bus.rf_rdata2 = rf_mem[bus.rf_raddr2];

   int n_tests = 0;
   int n_fail  = 0;

   // scoreboard of expected {tag, op1, op2} per transfer to EXE
   logic [95:0] exp_q [$];

   // ---------------- model state ----------------
   logic        m_hold_v;
   logic [31:0] m_tag;
   logic [4:0]  m_src1, m_src2;
   logic        m_use1, m_use2;
   logic        m_out_v;
   logic [31:0] m_out_tag, m_op1, m_op2;
   logic [31:0] m_stall;

   task automatic chk(input string name, input logic [95:0] act, input logic [95:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s actual=%0h required=%0h", name, act, exp);
      end
   endtask

   // operand value for one source: youngest writer wins, r0/unused is 0
   function automatic void resolve(input logic [4:0] a, input logic u,
                                   output logic [31:0] v, output logic h);
      logic        we [3];
      logic [4:0]  ad [3];
      logic [31:0] dt [3];
      logic        rd [3];
      we = '{bus.exe_fwd_we, bus.mem_fwd_we, bus.wb_fwd_we};
      ad = '{bus.exe_fwd_addr, bus.mem_fwd_addr, bus.wb_fwd_addr};
      dt = '{bus.exe_fwd_data, bus.mem_fwd_data, bus.wb_fwd_data};
      rd = '{bus.exe_fwd_rdy, bus.mem_fwd_rdy, 1'b1};
      v = '0;
      h = 1'b0;
      if (a == 5'd0 || !u) return;
      for (int i = 0; i < 3; i++) begin
         if (we[i] && ad[i] == a) begin
            v = dt[i];
            h = !rd[i];
            return;
         end
      end
      v = rf_mem[a];
   endfunction

   // one clock: check combinational outputs, advance model, check registers
   task automatic step();
      logic [31:0] v1, v2;
      logic        h1, h2, go, fire, aw;
      @(negedge clk);
      resolve(m_src1, m_use1, v1, h1);
      resolve(m_src2, m_use2, v2, h2);
      go   = m_hold_v && !h1 && !h2;
      fire = go && (!m_out_v || bus.out_allowin);
      aw   = !m_hold_v || fire;
      if (!reset) begin
         chk("in_allowin", {95'd0, bus.in_allowin}, {95'd0, aw});
         if (m_hold_v) begin
            chk("rf_raddr1", {91'd0, bus.rf_raddr1}, {91'd0, m_src1});
            chk("rf_raddr2", {91'd0, bus.rf_raddr2}, {91'd0, m_src2});
         end
      end
      if (reset) begin
         m_hold_v = 0; m_out_v = 0; m_out_tag = 0; m_op1 = 0; m_op2 = 0; m_stall = 0;
         m_tag = 0; m_src1 = 0; m_src2 = 0; m_use1 = 0; m_use2 = 0;
      end else if (bus.flush) begin
         m_hold_v = 0;
         m_out_v  = 0;
      end else begin
         if (m_hold_v && !go && m_stall != 32'hFFFF_FFFF) m_stall = m_stall + 1;
         if (fire) begin
            m_out_v = 1; m_out_tag = m_tag; m_op1 = v1; m_op2 = v2;
         end else if (bus.out_allowin) begin
            m_out_v = 0;
         end
         if (bus.in_valid && aw) begin
            m_hold_v = 1; m_tag = bus.in_tag;
            m_src1 = bus.in_src1; m_src2 = bus.in_src2;
            m_use1 = bus.in_use1; m_use2 = bus.in_use2;
         end else if (fire) begin
            m_hold_v = 0;
         end
      end
      @(posedge clk);
      #1;
      chk("out_valid", {95'd0, bus.out_valid}, {95'd0, m_out_v});
      chk("out_tag",   {64'd0, bus.out_tag},   {64'd0, m_out_tag});
      chk("out_op1",   {64'd0, bus.out_op1},   {64'd0, m_op1});
      chk("out_op2",   {64'd0, bus.out_op2},   {64'd0, m_op2});
      chk("stall_cnt", {64'd0, bus.stall_cnt}, {64'd0, m_stall});
      chk("dbg_state", {95'd0, dbg_state},     {95'd0, m_hold_v});
   endtask

   // ---------------- transfer monitor ----------------
   always @(negedge clk) begin
      if (!reset && bus.out_valid === 1'b1 && bus.out_allowin === 1'b1) begin
         if (exp_q.size() == 0) begin
            n_tests++;
            n_fail++;
            $display("FAIL xfer_unexpected actual=%0h required=none",
                     {bus.out_tag, bus.out_op1, bus.out_op2});
         end else begin
            chk("xfer", {bus.out_tag, bus.out_op1, bus.out_op2}, exp_q.pop_front());
         end
      end
   end

   // ---------------- driver tasks ----------------
   task automatic send(input logic [31:0] tag, input logic [4:0] s1, input logic [4:0] s2,
                       input logic u1, input logic u2);
      bus.in_valid = 1'b1;
      bus.in_tag   = tag;
      bus.in_src1  = s1;
      bus.in_src2  = s2;
      bus.in_use1  = u1;
      bus.in_use2  = u2;
      step();
      bus.in_valid = 1'b0;
   endtask

   task automatic clear_fwd();
      bus.exe_fwd_we = 0; bus.exe_fwd_addr = 0; bus.exe_fwd_data = 0; bus.exe_fwd_rdy = 1;
      bus.mem_fwd_we = 0; bus.mem_fwd_addr = 0; bus.mem_fwd_data = 0; bus.mem_fwd_rdy = 1;
      bus.wb_fwd_we  = 0; bus.wb_fwd_addr  = 0; bus.wb_fwd_data  = 0;
   endtask

   // ---------------- stimulus ----------------
   initial begin
      for (int i = 0; i < 32; i++) rf_mem[i] = 32'h1000 + i;
      rf_mem[3] = 32'h11;
      rf_mem[4] = 32'h22;
      m_hold_v = 0; m_out_v = 0; m_out_tag = 0; m_op1 = 0; m_op2 = 0; m_stall = 0;
      m_tag = 0; m_src1 = 0; m_src2 = 0; m_use1 = 0; m_use2 = 0;
      reset = 1'b1;
      bus.flush = 0; bus.in_valid = 0; bus.in_tag = 0;
      bus.in_src1 = 0; bus.in_src2 = 0; bus.in_use1 = 0; bus.in_use2 = 0;
      bus.out_allowin = 1'b1;
      clear_fwd();
      step();
      step();
      reset = 1'b0;
      step();
      chk("rst_out_valid", {95'd0, bus.out_valid}, 96'd0);
      chk("rst_out_tag",   {64'd0, bus.out_tag},   96'd0);
      chk("rst_stall_cnt", {64'd0, bus.stall_cnt}, 96'd0);
      chk("rst_in_allowin", {95'd0, bus.in_allowin}, 96'd1);

      // no dependencies: operands straight from the regfile
      exp_q.push_back({32'h100, 32'h11, 32'h22});
      send(32'h100, 5'd3, 5'd4, 1'b1, 1'b1);
      step();
      chk("t1_op1", {64'd0, bus.out_op1}, {64'd0, 32'h11});
      chk("t1_op2", {64'd0, bus.out_op2}, {64'd0, 32'h22});
      step();
      step();

      // forwarding priority: EXE over MEM over WB
      bus.exe_fwd_we = 1; bus.exe_fwd_addr = 5; bus.exe_fwd_data = 32'hA; bus.exe_fwd_rdy = 1;
      bus.mem_fwd_we = 1; bus.mem_fwd_addr = 5; bus.mem_fwd_data = 32'hB; bus.mem_fwd_rdy = 1;
      bus.wb_fwd_we  = 1; bus.wb_fwd_addr  = 5; bus.wb_fwd_data  = 32'hC;
      exp_q.push_back({32'h200, 32'hA, 32'h0});
      send(32'h200, 5'd5, 5'd0, 1'b1, 1'b0);
      step();
      chk("t2_exe_wins", {64'd0, bus.out_op1}, {64'd0, 32'hA});
      bus.exe_fwd_we = 0;
      exp_q.push_back({32'h204, 32'hB, 32'hB});
      send(32'h204, 5'd5, 5'd5, 1'b1, 1'b1);
      step();
      chk("t2_mem_wins", {64'd0, bus.out_op1}, {64'd0, 32'hB});
      step();
      clear_fwd();
      step();

      // load-use: one hazard cycle, then data arrives from MEM
      bus.exe_fwd_we = 1; bus.exe_fwd_addr = 7; bus.exe_fwd_data = 32'hDEAD; bus.exe_fwd_rdy = 0;
      exp_q.push_back({32'h300, 32'h77, 32'h11});
      send(32'h300, 5'd7, 5'd3, 1'b1, 1'b1);
      step();
      chk("t3_stall_once", {64'd0, bus.stall_cnt}, 96'd1);
      chk("t3_no_out", {95'd0, bus.out_valid}, 96'd0);
      clear_fwd();
      bus.mem_fwd_we = 1; bus.mem_fwd_addr = 7; bus.mem_fwd_data = 32'h77; bus.mem_fwd_rdy = 1;
      step();
      chk("t3_op1", {64'd0, bus.out_op1}, {64'd0, 32'h77});
      clear_fwd();
      step();
      step();

      // r0 never depends on a writer, even a not-ready one
      bus.exe_fwd_we = 1; bus.exe_fwd_addr = 0; bus.exe_fwd_data = 32'h5555; bus.exe_fwd_rdy = 0;
      exp_q.push_back({32'h400, 32'h0, 32'h22});
      send(32'h400, 5'd0, 5'd4, 1'b1, 1'b1);
      step();
      chk("t4_r0_valid", {95'd0, bus.out_valid}, 96'd1);
      chk("t4_r0_op1", {64'd0, bus.out_op1}, 96'd0);
      clear_fwd();
      step();
      chk("t4_stall_kept", {64'd0, bus.stall_cnt}, 96'd1);

      // back-pressure: output stalls three cycles with a ready reload behind it
      bus.out_allowin = 1'b0;
      exp_q.push_back({32'h500, 32'h11, 32'h22});
      exp_q.push_back({32'h504, 32'h11, 32'h22});
      exp_q.push_back({32'h508, 32'h22, 32'h11});
      send(32'h500, 5'd3, 5'd4, 1'b1, 1'b1);
      bus.in_valid = 1; bus.in_tag = 32'h504; bus.in_src1 = 3; bus.in_src2 = 4;
      step();
      bus.in_tag = 32'h508; bus.in_src1 = 4; bus.in_src2 = 3;
      for (int i = 0; i < 3; i++) begin
         step();
         chk("t5_allowin_low", {95'd0, bus.in_allowin}, 96'd0);
         chk("t5_tag_stable", {64'd0, bus.out_tag}, {64'd0, 32'h500});
         chk("t5_stall_same", {64'd0, bus.stall_cnt}, 96'd1);
      end
      bus.out_allowin = 1'b1;
      step();
      bus.in_valid = 0;
      step();
      step();
      step();

      // flush during a hazard keeps the counter, reset clears it
      bus.exe_fwd_we = 1; bus.exe_fwd_addr = 9; bus.exe_fwd_data = 32'h99; bus.exe_fwd_rdy = 0;
      send(32'h600, 5'd9, 5'd0, 1'b1, 1'b0);
      step();
      bus.flush = 1; bus.in_valid = 1; bus.in_tag = 32'h604; bus.in_src1 = 3; bus.in_src2 = 4;
      step();
      bus.flush = 0; bus.in_valid = 0;
      chk("t6_flush_out", {95'd0, bus.out_valid}, 96'd0);
      chk("t6_flush_stall", {64'd0, bus.stall_cnt}, 96'd2);
      chk("t6_flush_empty", {95'd0, bus.in_allowin}, 96'd1);
      step();
      send(32'h700, 5'd9, 5'd0, 1'b1, 1'b0);
      step();
      chk("t6_stall_more", {64'd0, bus.stall_cnt}, 96'd3);
      reset = 1'b1;
      step();
      reset = 1'b0;
      chk("t6_rst_stall", {64'd0, bus.stall_cnt}, 96'd0);
      chk("t6_rst_out", {95'd0, bus.out_valid}, 96'd0);
      chk("t6_rst_allowin", {95'd0, bus.in_allowin}, 96'd1);
      clear_fwd();
      step();
      step();

      n_tests++;
      if (exp_q.size() != 0) begin
         n_fail++;
         $display("FAIL xfer_missing actual=%0d required=0", exp_q.size());
      end
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
